// File: rtl/msix_irq_sched_pkg.sv
// Shared types and constants for the MSI-X interrupt scheduler.
package msix_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  localparam int unsigned VECW             = $clog2(32);
  localparam int unsigned MSIX_ADDR_STRIDE = 16;

  function automatic logic [63:0] msix_vec_addr(input logic [63:0]     base,
                                                input logic [VECW-1:0] vec);
    return base + (64'(vec) * 64'(MSIX_ADDR_STRIDE));
  endfunction

endpackage

// File: rtl/msix_irq_sched_if.sv
// MSI-X endpoint interrupt port bundle (cfg_interrupt_msix_*).
interface msix_irq_sched_if;

  logic [3:0]  cfg_interrupt_msix_enable;
  logic [3:0]  cfg_interrupt_msix_mask;
  logic        cfg_interrupt_msix_sent;
  logic        cfg_interrupt_msix_fail;
  logic        cfg_interrupt_msix_int;
  logic [31:0] cfg_interrupt_msix_data;
  logic [63:0] cfg_interrupt_msix_address;

  modport master (
    input  cfg_interrupt_msix_enable,
    input  cfg_interrupt_msix_mask,
    input  cfg_interrupt_msix_sent,
    input  cfg_interrupt_msix_fail,
    output cfg_interrupt_msix_int,
    output cfg_interrupt_msix_data,
    output cfg_interrupt_msix_address
  );

  modport slave (
    output cfg_interrupt_msix_enable,
    output cfg_interrupt_msix_mask,
    output cfg_interrupt_msix_sent,
    output cfg_interrupt_msix_fail,
    input  cfg_interrupt_msix_int,
    input  cfg_interrupt_msix_data,
    input  cfg_interrupt_msix_address
  );

endinterface

// File: rtl/msix_irq_sched_rr_arb.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_arb #(
  parameter int unsigned NREQ = 8,
  parameter int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PTRW-1:0] ptr,
  output logic            gnt_vld,
  output logic [PTRW-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && req[idx[PTRW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[PTRW-1:0];
      end
    end
  end

endmodule

// File: rtl/msix_irq_sched.sv
// Round-robin scheduler of NREQ interrupt sources onto one MSI-X endpoint port.
// Optional WAIT watchdog enabled by defining MSIX_SCHED_TIMEOUT_EN.
module msix_irq_sched
  import msix_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 8,
  parameter logic [63:0] ADDR_BASE = 64'hFEE0_0000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TMO_CYC   = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [NREQ-1:0]  irq_req,
  output logic [NREQ-1:0]  irq_ack,
  output logic [NREQ-1:0]  irq_drop,
  msix_irq_sched_if.master msix_if,
  output logic             busy,
  output logic [NREQ-1:0]  pending
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned RETW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_e    state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] req_prev_q, req_prev_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [VECW-1:0] vec_q, vec_d;
  logic [RETW-1:0] retry_q, retry_d;

  logic [NREQ-1:0] req_rise;
  logic [NREQ-1:0] pend_clr;
  logic [PTRW-1:0] gnt_idx;
  logic            gnt_vld;
  logic            eligible;
  logic            fail_evt;
  logic            tmo_hit;
  logic [5:0]      unused_cfg;

  rr_arb #(
    .NREQ (NREQ),
    .PTRW (PTRW)
  ) u_rr_arb (
    .req     (pend_q),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign req_rise   = irq_req & ~req_prev_q;
  assign eligible   = msix_if.cfg_interrupt_msix_enable[0] & ~msix_if.cfg_interrupt_msix_mask[0];
  assign fail_evt   = msix_if.cfg_interrupt_msix_fail | tmo_hit;
  assign unused_cfg = {msix_if.cfg_interrupt_msix_enable[3:1], msix_if.cfg_interrupt_msix_mask[3:1]};

  assign busy    = (state_q != IDLE);
  assign pending = pend_q;

  // Vector-derived outputs stay valid for the whole ISSUE..WAIT span, zero in IDLE.
  assign msix_if.cfg_interrupt_msix_int     = (state_q == ISSUE);
  assign msix_if.cfg_interrupt_msix_data    = busy ? (32'd1 << vec_q) : '0;
  assign msix_if.cfg_interrupt_msix_address = busy ? msix_vec_addr(ADDR_BASE, vec_q) : '0;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    ptr_d      = ptr_q;
    retry_d    = retry_q;
    pend_clr   = '0;
    irq_ack    = '0;
    irq_drop   = '0;
    req_prev_d = irq_req;

    case (state_q)
      IDLE: begin
        if (gnt_vld && eligible) begin
          vec_d    = VECW'(gnt_idx);
          ptr_d    = (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);
          pend_clr = NREQ'(1) << gnt_idx;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (msix_if.cfg_interrupt_msix_sent) begin
          irq_ack = NREQ'(1) << vec_q;
          retry_d = '0;
          state_d = IDLE;
        end else if (fail_evt) begin
          if (retry_q < RETW'(MAX_RETRY)) begin
            retry_d = retry_q + RETW'(1);
            state_d = ISSUE;
          end else begin
            irq_drop = NREQ'(1) << vec_q;
            retry_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the granted source re-arms it behind the current interrupt.
    pend_d = (pend_q & ~pend_clr) | req_rise;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      req_prev_q <= '0;
      ptr_q      <= '0;
      vec_q      <= '0;
      retry_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_prev_q <= req_prev_d;
      ptr_q      <= ptr_d;
      vec_q      <= vec_d;
      retry_q    <= retry_d;
    end
  end

`ifdef MSIX_SCHED_TIMEOUT_EN
  localparam int unsigned TMOW = $clog2(TMO_CYC + 1);

  logic [TMOW-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ISSUE) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMOW'(1);
    end
  end

  // Fires in the TMO_CYC-th WAIT cycle, so the reissue lands TMO_CYC cycles after WAIT entry.
  assign tmo_hit = (state_q == WAIT) && !msix_if.cfg_interrupt_msix_sent &&
                   !msix_if.cfg_interrupt_msix_fail && (tmo_cnt_q == TMOW'(TMO_CYC - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] unused_tmo_cyc;

  assign unused_tmo_cyc = TMO_CYC;
  assign tmo_hit        = 1'b0;
`endif

endmodule

// File: tb/tb_msix_irq_sched.sv
// Bench for msix_irq_sched: cycle model compared every cycle plus directed literal checks.
module tb_msix_irq_sched;

  localparam int          NREQ  = 8;
  localparam logic [63:0] ABASE = 64'hFEE0_0000;
  localparam int          MAXR  = 3;
  localparam int          TMO   = 16;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] irq_req = '0;
  logic [7:0] irq_ack, irq_drop, pending;
  logic       busy;

  msix_irq_sched_if ifc ();

  msix_irq_sched #(
    .NREQ      (NREQ),
    .ADDR_BASE (ABASE),
    .MAX_RETRY (MAXR),
    .TMO_CYC   (TMO)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .irq_req  (irq_req),
    .irq_ack  (irq_ack),
    .irq_drop (irq_drop),
    .msix_if  (ifc),
    .busy     (busy),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [31:0] data; logic [63:0] addr;} int_ev_t;
  typedef struct {int cyc; logic [7:0] v;} pulse_t;
  int_ev_t int_log[$];
  pulse_t  ack_log[$];
  pulse_t  drop_log[$];

  // Endpoint: mode 0 = sent 2 cycles after int, 1 = fail for vector 2 else sent, 2 = silent
  int          ep_mode = 0;
  int          ep_due  = -1;
  logic [31:0] ep_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state, meaning of the current cycle: phase 0 idle, 1 issuing, 2 waiting.
  logic [7:0] m_pend  = '0;
  logic [7:0] m_prev  = '0;
  logic [7:0] m_rise  = '0;
  int         m_ptr   = 0;
  int         m_phase = 0;
  int         m_vec   = 0;
  int         m_tries = 0;
  int         m_wcyc  = 0;
  bit         m_found = 0;

  function automatic bit m_fail_now();
    bit f;
    f = ifc.cfg_interrupt_msix_fail;
`ifdef MSIX_SCHED_TIMEOUT_EN
    if (!ifc.cfg_interrupt_msix_sent && m_wcyc == TMO - 1) f = 1'b1;
`endif
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_prev = '0; m_ptr = 0; m_phase = 0;
      m_vec = 0; m_tries = 0; m_wcyc = 0;
    end else begin
      m_rise = irq_req & ~m_prev;
      m_prev = irq_req;
      case (m_phase)
        0: begin
          if (m_pend != 0 && ifc.cfg_interrupt_msix_enable[0] && !ifc.cfg_interrupt_msix_mask[0]) begin
            m_found = 0;
            for (int k = 0; k < NREQ; k++) begin
              if (!m_found && m_pend[(m_ptr + k) % NREQ]) begin
                m_vec   = (m_ptr + k) % NREQ;
                m_found = 1;
              end
            end
            m_pend[m_vec] = 1'b0;
            m_ptr   = (m_vec + 1) % NREQ;
            m_tries = 1;
            m_phase = 1;
          end
        end
        1: begin
          m_phase = 2;
          m_wcyc  = 0;
        end
        default: begin
          if (ifc.cfg_interrupt_msix_sent) m_phase = 0;
          else if (m_fail_now()) begin
            if (m_tries <= MAXR) begin
              m_tries++;
              m_phase = 1;
            end else m_phase = 0;
          end else m_wcyc++;
        end
      endcase
      m_pend = m_pend | m_rise;
    end
  end

  always @(negedge clk) begin
    logic [7:0] e_ack, e_drop;
    e_ack  = (m_phase == 2 && ifc.cfg_interrupt_msix_sent) ? 8'(1 << m_vec) : 8'h00;
    e_drop = (m_phase == 2 && !ifc.cfg_interrupt_msix_sent && m_fail_now() && m_tries > MAXR)
             ? 8'(1 << m_vec) : 8'h00;
    check("int",     64'(ifc.cfg_interrupt_msix_int), 64'(m_phase == 1));
    check("data",    64'(ifc.cfg_interrupt_msix_data), (m_phase != 0) ? 64'(32'd1 << m_vec) : 64'd0);
    check("address", ifc.cfg_interrupt_msix_address, (m_phase != 0) ? ABASE + 64'(m_vec * 16) : 64'd0);
    check("busy",    64'(busy), 64'(m_phase != 0));
    check("pending", 64'(pending), 64'(m_pend));
    check("ack",     64'(irq_ack), 64'(e_ack));
    check("drop",    64'(irq_drop), 64'(e_drop));
    if (ifc.cfg_interrupt_msix_int === 1'b1) begin
      int_log.push_back('{cyc, ifc.cfg_interrupt_msix_data, ifc.cfg_interrupt_msix_address});
      ep_due  = cyc + 2;
      ep_data = ifc.cfg_interrupt_msix_data;
    end
    if (irq_ack  != 0) ack_log.push_back('{cyc, irq_ack});
    if (irq_drop != 0) drop_log.push_back('{cyc, irq_drop});
  end

  initial begin
    ifc.cfg_interrupt_msix_sent = 1'b0;
    ifc.cfg_interrupt_msix_fail = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.cfg_interrupt_msix_sent = 1'b0;
      ifc.cfg_interrupt_msix_fail = 1'b0;
      if (cyc == ep_due) begin
        if (ep_mode == 0) ifc.cfg_interrupt_msix_sent = 1'b1;
        else if (ep_mode == 1) begin
          if (ep_data == 32'h4) ifc.cfg_interrupt_msix_fail = 1'b1;
          else ifc.cfg_interrupt_msix_sent = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    int_log.delete();
    ack_log.delete();
    drop_log.delete();
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ep_due = -1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  int          c0;
  logic [31:0] order2[4];

  initial begin
    ifc.cfg_interrupt_msix_enable = 4'h1;
    ifc.cfg_interrupt_msix_mask   = 4'h0;
    irq_req = '0;
    rst_n   = 1'b0;
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Single request on source 3
    ep_mode = 0;
    clear_logs();
    irq_req = 8'h08; c0 = cyc;
    tick(1); irq_req = '0;
    tick(10);
    check("t1_nint", 64'(int_log.size()), 64'd1);
    if (int_log.size() > 0) begin
      check("t1_int_cyc", 64'(int_log[0].cyc), 64'(c0 + 2));
      check("t1_data", 64'(int_log[0].data), 64'h8);
      check("t1_addr", int_log[0].addr, 64'hFEE0_0030);
    end
    check("t1_nack", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() > 0) begin
      check("t1_ack_cyc", 64'(ack_log[0].cyc), 64'(c0 + 4));
      check("t1_ack_val", 64'(ack_log[0].v), 64'h08);
    end

    // Simultaneous 1,5,6 from ptr 0, then wrap to 0
    do_reset();
    clear_logs();
    irq_req = 8'h62;
    tick(1); irq_req = '0;
    tick(20);
    irq_req = 8'h01;
    tick(1); irq_req = '0;
    tick(10);
    order2 = '{32'h2, 32'h20, 32'h40, 32'h1};
    check("t2_nint", 64'(int_log.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < int_log.size()) check("t2_order", 64'(int_log[i].data), 64'(order2[i]));

    // Source 2 always fails: 4 attempts then drop, source 4 next
    ep_mode = 1;
    clear_logs();
    irq_req = 8'h14; c0 = cyc;
    tick(1); irq_req = '0;
    tick(30);
    check("t3_nint", 64'(int_log.size()), 64'd5);
    for (int i = 0; i < 4; i++)
      if (i < int_log.size()) check("t3_retry_data", 64'(int_log[i].data), 64'h4);
    if (int_log.size() > 4) begin
      check("t3_next_data", 64'(int_log[4].data), 64'h10);
      check("t3_next_cyc", 64'(int_log[4].cyc), 64'(c0 + 15));
    end
    check("t3_ndrop", 64'(drop_log.size()), 64'd1);
    if (drop_log.size() > 0) begin
      check("t3_drop_val", 64'(drop_log[0].v), 64'h04);
      check("t3_drop_cyc", 64'(drop_log[0].cyc), 64'(c0 + 13));
    end
    check("t3_nack", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() > 0) check("t3_ack_val", 64'(ack_log[0].v), 64'h10);

    // Masked accumulation of sources 0 and 7
    do_reset();
    ep_mode = 0;
    clear_logs();
    ifc.cfg_interrupt_msix_mask = 4'h1;
    irq_req = 8'h81;
    tick(1); irq_req = '0;
    tick(6);
    check("t4_pending", 64'(pending), 64'h81);
    check("t4_masked_nint", 64'(int_log.size()), 64'd0);
    ifc.cfg_interrupt_msix_mask = 4'h0;
    tick(15);
    check("t4_nint", 64'(int_log.size()), 64'd2);
    if (int_log.size() > 1) begin
      check("t4_first", 64'(int_log[0].data), 64'h1);
      check("t4_second", 64'(int_log[1].data), 64'h80);
    end

    // Reset while waiting on a silent endpoint
    ep_mode = 2;
    clear_logs();
    irq_req = 8'h08;
    tick(1); irq_req = '0;
    tick(4);
    check("t5_busy_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_int", 64'(ifc.cfg_interrupt_msix_int), 64'd0);
    check("t5_rst_data", 64'(ifc.cfg_interrupt_msix_data), 64'd0);
    check("t5_rst_addr", ifc.cfg_interrupt_msix_address, 64'd0);
    check("t5_rst_pending", 64'(pending), 64'd0);
    check("t5_rst_ack", 64'(irq_ack), 64'd0);
    check("t5_rst_drop", 64'(irq_drop), 64'd0);
    tick(2);
    rst_n   = 1'b1;
    ep_due  = -1;
    ep_mode = 0;
    tick(3);
    check("t5_no_ack", 64'(ack_log.size() + drop_log.size()), 64'd0);
    clear_logs();
    irq_req = 8'h20; c0 = cyc;
    tick(1); irq_req = '0;
    tick(8);
    check("t5_nint", 64'(int_log.size()), 64'd1);
    if (int_log.size() > 0) begin
      check("t5_int_cyc", 64'(int_log[0].cyc), 64'(c0 + 2));
      check("t5_data", 64'(int_log[0].data), 64'h20);
    end
    check("t5_nack", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() > 0) check("t5_ack_val", 64'(ack_log[0].v), 64'h20);

`ifdef MSIX_SCHED_TIMEOUT_EN
    // Silent endpoint: watchdog reissues every TMO_CYC+1 cycles, drops after 4 attempts
    ep_mode = 2;
    clear_logs();
    irq_req = 8'h40;
    tick(1); irq_req = '0;
    tick(90);
    check("t6_nint", 64'(int_log.size()), 64'd4);
    for (int i = 1; i < 4; i++)
      if (i < int_log.size()) check("t6_period", 64'(int_log[i].cyc - int_log[i-1].cyc), 64'(TMO + 1));
    check("t6_ndrop", 64'(drop_log.size()), 64'd1);
    if (drop_log.size() > 0 && int_log.size() > 3) begin
      check("t6_drop_val", 64'(drop_log[0].v), 64'h40);
      check("t6_drop_cyc", 64'(drop_log[0].cyc), 64'(int_log[3].cyc + TMO));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
